// File: rtl/capture_fifo_if.sv
// capture_fifo_if
//   Handshake and status bundle for capture_fifo.
//   master : producer/sink side (drives in_valid, in_data, out_ready)
//   slave  : FIFO side (drives in_ready, out_valid, out_data and status)
//   Signals:
//     in_valid/in_data/in_ready     write-side valid/ready
//     out_valid/out_data/out_ready  read-side valid/ready (FWFT head)
//     count                         occupancy 0..DEPTH (AW+1 bits)
//     full/empty/almost_full        decoded from the registered count
//     overflow                      sticky, push attempted while full
interface capture_fifo_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  count, full, empty, almost_full, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output count, full, empty, almost_full, overflow
    );
endinterface

// File: rtl/capture_fifo.sv
// capture_fifo
//   16-entry first-word-fall-through FIFO that buffers samples from the
//   registered 8-bit datapath and presents them to a valid/ready sink.
//   Ports:
//     clk   rising-edge clock
//     rstn  asynchronous active-low reset (pointers, count, overflow)
//     clr   synchronous active-high flush; dominates push/pop
//     bus   capture_fifo_if.slave: write/read handshakes plus
//           count, full, empty, almost_full and sticky overflow
//   Status flags decode only from the registered count, so there is no
//   combinational path from in_valid to out_valid or out_ready to in_ready.
module capture_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned AFULL = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    capture_fifo_if.slave        bus
);
    localparam int unsigned CW = AW + 1;

    // Storage is not reset; only pointers, count and overflow are.
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_almost_full;
    logic          w_push;
    logic          w_pop;

    // Flag decode from registered state.
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_almost_full = (r_count >= CW'(AFULL));

    // Handshakes qualify against the registered flags only.
    assign w_push = bus.in_valid  && !w_full;
    assign w_pop  = bus.out_ready && !w_empty;

    assign bus.in_ready    = !w_full;
    assign bus.out_valid   = !w_empty;
    assign bus.out_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = w_almost_full;
    assign bus.overflow    = r_overflow;

    // Data array write. A write during clr is harmless: the pointer is
    // reset, so the entry is unreachable until overwritten by a new push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Any attempted push while full is recorded, even if a pop
            // frees an entry on the same edge.
            if (bus.in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Structural sanity.
    a_count_range : assert property (@(posedge clk) disable iff (!rstn)
        r_count <= CW'(DEPTH));
    a_ptr_consistent : assert property (@(posedge clk) disable iff (!rstn)
        (r_count != CW'(DEPTH) && r_count != '0) |->
        (AW'(r_wr_ptr - r_rd_ptr) == AW'(r_count)));

endmodule

// File: tb/tb_capture_fifo.sv
// tb_capture_fifo
//   Directed-vector bench for capture_fifo with hand-computed expectations.
module tb_capture_fifo;
    logic clk;
    logic rstn;
    logic clr;
    int unsigned n_checks;
    int unsigned n_errors;

    capture_fifo_if #(.DW(8), .AW(4)) bus ();

    capture_fifo #(
        .DW   (8),
        .DEPTH(16),
        .AW   (4),
        .AFULL(12)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b0;
        clr  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;

        // Reset state
        check("rst_empty",  32'(bus.empty),       1);
        check("rst_full",   32'(bus.full),        0);
        check("rst_afull",  32'(bus.almost_full), 0);
        check("rst_inrdy",  32'(bus.in_ready),    1);
        check("rst_ovalid", 32'(bus.out_valid),   0);
        check("rst_odata",  32'(bus.out_data),    0);
        check("rst_count",  32'(bus.count),       0);
        check("rst_ovf",    32'(bus.overflow),    0);
        rstn = 1'b1;
        tick();

        // Pop request while empty is ignored; push+pop while empty only pushes
        bus.out_ready = 1'b1;
        tick();
        check("empty_pop_ignored", 32'(bus.count), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        tick();
        check("empty_pushpop_cnt", 32'(bus.count),    1);
        check("empty_pushpop_dat", 32'(bus.out_data), 32'h C3);
        bus.in_valid = 1'b0;
        tick();
        check("empty_drain", 32'(bus.empty), 1);
        bus.out_ready = 1'b0;

        // Basic ordering: push 01..03 then drain
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            tick();
            if (i == 1) begin
                check("lat_ovalid", 32'(bus.out_valid), 1);
                check("lat_odata",  32'(bus.out_data),  1);
            end
        end
        bus.in_valid = 1'b0;
        check("b3_count",  32'(bus.count),     3);
        check("b3_ovalid", 32'(bus.out_valid), 1);
        check("b3_odata",  32'(bus.out_data),  1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("b3_pop_data", 32'(bus.out_data), 32'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("b3_empty", 32'(bus.empty),    1);
        check("b3_odata0", 32'(bus.out_data), 0);

        // Fill 16, almost_full/full boundaries, overflow push
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + i);
            tick();
            check("fill_count", 32'(bus.count),       32'(i + 1));
            check("fill_afull", 32'(bus.almost_full), (i + 1 >= 12) ? 1 : 0);
            check("fill_full",  32'(bus.full),        (i + 1 == 16) ? 1 : 0);
        end
        check("full_inrdy", 32'(bus.in_ready), 0);
        bus.in_data = 8'hAA;
        tick();
        bus.in_valid = 1'b0;
        check("ovf_set",   32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count),    16);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain16_data", 32'(bus.out_data), 32'(8'h10 + i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("drain16_empty", 32'(bus.empty),    1);
        check("ovf_sticky",    32'(bus.overflow), 1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovf", 32'(bus.overflow), 0);

        // Streaming at count=8 across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h20 + i);
            tick();
        end
        check("stream_pre_count", 32'(bus.count), 8);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            bus.in_data = 8'(8'h28 + j);
            check("stream_data", 32'(bus.out_data), 32'(8'h20 + j));
            tick();
            check("stream_count", 32'(bus.count), 8);
        end
        bus.in_valid = 1'b0;
        for (int j = 20; j < 28; j++) begin
            check("stream_tail", 32'(bus.out_data), 32'(8'h20 + j));
            tick();
        end
        bus.out_ready = 1'b0;
        check("stream_empty", 32'(bus.empty), 1);

        // Full with simultaneous push attempt and pop
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h40 + i);
            tick();
        end
        check("sim_full", 32'(bus.full), 1);
        bus.in_data   = 8'hBB;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("sim_count", 32'(bus.count),    15);
        check("sim_ovf",   32'(bus.overflow), 1);
        check("sim_inrdy", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("sim_drain", 32'(bus.out_data), 32'(8'h40 + i));
            tick();
        end
        bus.out_ready = 1'b0;
        check("sim_empty", 32'(bus.empty), 1);

        // clr dominates a push; overflow still set from the previous case
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h50 + i);
            tick();
        end
        check("clr_pre_count", 32'(bus.count),    5);
        check("clr_pre_ovf",   32'(bus.overflow), 1);
        clr          = 1'b1;
        bus.in_data  = 8'h55;
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_count", 32'(bus.count),    0);
        check("clr_empty", 32'(bus.empty),    1);
        check("clr_ovf2",  32'(bus.overflow), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        tick();
        bus.in_valid = 1'b0;
        check("clr_next_data",  32'(bus.out_data), 32'h66);
        check("clr_next_count", 32'(bus.count),    1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h70 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("arst_pre_count", 32'(bus.count), 7);
        #4;
        rstn = 1'b0;
        #1;
        check("arst_count",  32'(bus.count),     0);
        check("arst_ovalid", 32'(bus.out_valid), 0);
        check("arst_odata",  32'(bus.out_data),  0);
        #2;
        rstn = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();
        bus.in_valid = 1'b0;
        check("arst_post_data",  32'(bus.out_data), 32'h77);
        check("arst_post_count", 32'(bus.count),    1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
